// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : wb_stage
//  Description : Writeback stage feeding the register-file write port.
//                Accepts completed instructions over a valid/ready handshake,
//                waits for load data when required, aligns and sign/zero-
//                extends it, then drives wa/wda/reg_wr for exactly one cycle
//                per retired instruction.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clock        in   1     system clock, rising edge
//    reset        in   1     asynchronous, active-high reset
//    in_valid     in   1     upstream instruction valid
//    in_ready     out  1     stage can accept (IDLE or COMMIT)
//    in_rd        in   RA_W  destination register
//    in_result    in   XLEN  ALU result / load byte address
//    in_pc4       in   XLEN  PC+4 for JAL/JALR link
//    in_sel       in   2     00 ALU, 01 LOAD, 10 PC+4, 11 no write
//    in_funct3    in   3     load type (0 LB,1 LH,2 LW,4 LBU,5 LHU)
//    mem_rvalid   in   1     load data valid pulse
//    mem_rdata    in   XLEN  raw aligned word from data memory
//    wa           out  RA_W  register-file write address
//    wda          out  XLEN  register-file write data
//    reg_wr       out  1     register-file write enable
//    load_err     out  1     misaligned / illegal load pulse
//    retire_cnt   out  32    retired-instruction counter (wraps)
// ============================================================================
module wb_stage #(
   parameter int XLEN = 32,
   parameter int RA_W = 5
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [RA_W-1:0] in_rd,
   input  logic [XLEN-1:0] in_result,
   input  logic [XLEN-1:0] in_pc4,
   input  logic [1:0]      in_sel,
   input  logic [2:0]      in_funct3,
   input  logic            mem_rvalid,
   input  logic [XLEN-1:0] mem_rdata,
   output logic [RA_W-1:0] wa,
   output logic [XLEN-1:0] wda,
   output logic            reg_wr,
   output logic            load_err,
   output logic [31:0]     retire_cnt
);

   // ---------------------------------------------------------------------
   // Encodings
   // ---------------------------------------------------------------------
   localparam logic [1:0] c_SEL_ALU  = 2'b00;
   localparam logic [1:0] c_SEL_LOAD = 2'b01;
   localparam logic [1:0] c_SEL_PC4  = 2'b10;
   localparam logic [1:0] c_SEL_NONE = 2'b11;

   localparam logic [2:0] c_F3_LB  = 3'd0;
   localparam logic [2:0] c_F3_LH  = 3'd1;
   localparam logic [2:0] c_F3_LW  = 3'd2;
   localparam logic [2:0] c_F3_LBU = 3'd4;
   localparam logic [2:0] c_F3_LHU = 3'd5;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_WAIT_MEM = 2'd1,
      S_COMMIT   = 2'd2
   } state_t;

   // ---------------------------------------------------------------------
   // State and registered outputs
   // ---------------------------------------------------------------------
   state_t            r_state;
   logic [RA_W-1:0]   r_rd;        // destination of the pending load
   logic [1:0]        r_addr;      // byte offset of the pending load
   logic [2:0]        r_funct3;    // width/sign of the pending load
   logic              r_err;       // pending load already known to be bad
   logic [RA_W-1:0]   r_wa;
   logic [XLEN-1:0]   r_wda;
   logic              r_reg_wr;
   logic              r_load_err;
   logic [31:0]       r_retire_cnt;

   // ---------------------------------------------------------------------
   // Combinational helpers
   // ---------------------------------------------------------------------
   logic              w_accept;
   logic              w_acc_err;
   logic [XLEN-1:0]   w_imm_val;
   logic              w_imm_wr;
   logic [7:0]        w_byte;
   logic [15:0]       w_half;
   logic [XLEN-1:0]   w_load_val;

   // Ready is a pure decode of the state register, so it is glitch-free
   // and already high in the cycle after reset is released.
   assign w_accept = in_valid && in_ready;

   always_comb begin
      in_ready = 1'b0;
      if ((r_state == S_IDLE) || (r_state == S_COMMIT)) begin
         in_ready = 1'b1;
      end
   end

   // Load legality is judged from the address presented at accept; the
   // memory access is still allowed to complete so the bus stays in step.
   always_comb begin
      w_acc_err = 1'b0;
      case (in_funct3)
         c_F3_LB, c_F3_LBU: w_acc_err = 1'b0;
         c_F3_LH, c_F3_LHU: w_acc_err = in_result[0];
         c_F3_LW:           w_acc_err = (in_result[1:0] != 2'b00);
         default:           w_acc_err = 1'b1;
      endcase
   end

   // Write value for instructions that do not touch memory. The no-write
   // selection carries zero; the enable is suppressed anyway.
   always_comb begin
      w_imm_val = '0;
      case (in_sel)
         c_SEL_ALU:  w_imm_val = in_result;
         c_SEL_PC4:  w_imm_val = in_pc4;
         default:    w_imm_val = '0;
      endcase
   end

   // Writing x0 is architecturally a no-op, so the enable is dropped for it.
   assign w_imm_wr = (in_sel != c_SEL_NONE) && (in_rd != '0);

   // Byte and halfword lanes of the returned word for the pending load.
   always_comb begin
      w_byte = mem_rdata[7:0];
      case (r_addr)
         2'd0:    w_byte = mem_rdata[7:0];
         2'd1:    w_byte = mem_rdata[15:8];
         2'd2:    w_byte = mem_rdata[23:16];
         default: w_byte = mem_rdata[31:24];
      endcase
   end

   always_comb begin
      w_half = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
   end

   always_comb begin
      w_load_val = mem_rdata;
      case (r_funct3)
         c_F3_LB:  w_load_val = {{(XLEN-8){w_byte[7]}}, w_byte};
         c_F3_LBU: w_load_val = {{(XLEN-8){1'b0}}, w_byte};
         c_F3_LH:  w_load_val = {{(XLEN-16){w_half[15]}}, w_half};
         c_F3_LHU: w_load_val = {{(XLEN-16){1'b0}}, w_half};
         c_F3_LW:  w_load_val = mem_rdata;
         default:  w_load_val = mem_rdata;
      endcase
   end

   // ---------------------------------------------------------------------
   // Control FSM with registered outputs
   // ---------------------------------------------------------------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_rd         <= '0;
         r_addr       <= '0;
         r_funct3     <= '0;
         r_err        <= 1'b0;
         r_wa         <= '0;
         r_wda        <= '0;
         r_reg_wr     <= 1'b0;
         r_load_err   <= 1'b0;
         r_retire_cnt <= '0;
      end else begin
         // Strobes are high only during the COMMIT cycle.
         r_reg_wr   <= 1'b0;
         r_load_err <= 1'b0;

         case (r_state)
            S_IDLE, S_COMMIT: begin
               if (w_accept) begin
                  r_rd     <= in_rd;
                  r_addr   <= in_result[1:0];
                  r_funct3 <= in_funct3;
                  if (in_sel == c_SEL_LOAD) begin
                     r_err   <= w_acc_err;
                     r_state <= S_WAIT_MEM;
                  end else begin
                     // Non-loads commit on the very next cycle, which is
                     // what gives back-to-back 1/cycle throughput.
                     r_err        <= 1'b0;
                     r_wa         <= in_rd;
                     r_wda        <= w_imm_val;
                     r_reg_wr     <= w_imm_wr;
                     r_retire_cnt <= r_retire_cnt + 32'd1;
                     r_state      <= S_COMMIT;
                  end
               end else begin
                  r_state <= S_IDLE;
               end
            end

            S_WAIT_MEM: begin
               if (mem_rvalid) begin
                  r_wa    <= r_rd;
                  r_wda   <= w_load_val;
                  r_state <= S_COMMIT;
                  if (r_err) begin
                     r_load_err <= 1'b1;
                  end else begin
                     r_reg_wr     <= (r_rd != '0);
                     r_retire_cnt <= r_retire_cnt + 32'd1;
                  end
               end
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign wa         = r_wa;
   assign wda        = r_wda;
   assign reg_wr     = r_reg_wr;
   assign load_err   = r_load_err;
   assign retire_cnt = r_retire_cnt;

endmodule
`default_nettype wire
